// File: rtl/ex_control.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer owning the PC and CPSR flags.
// Optional macro EX_CTRL_BL_EN makes branch-group ALU_OC 010 a branch-and-link.
module ex_control #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ir,
   input  logic [1:0]  First_LD,
   input  logic        Special_encoding,
   input  logic [3:0]  Second_LD,
   input  logic [2:0]  ALU_OC,
   input  logic [3:0]  B_cond,
   input  logic [2:0]  dest_reg,
   input  logic [15:0] offset,
   input  logic [32:0] alu_result,
   input  logic [3:0]  alu_flags,
   output logic [31:0] pc,
   output logic [3:0]  flags,
   output logic        wb_en,
   output logic [2:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic        halted
);

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

   state_t             state, state_nxt;
   logic [31:0]        pc_next_q;
   logic [31:0]        pc_nxt;
   logic [31:0]        target;
   logic signed [31:0] off_ext;
   logic               wb_vld;
   logic               take;
   logic               do_halt;
   logic [2:0]         wb_idx;
   logic [31:0]        wb_val;
   logic               unused_bits;

   // flags layout is {N,C,Z,V}
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, cy, z, v;
      n  = f[3];
      cy = f[2];
      z  = f[1];
      v  = f[0];
      case (c)
         4'h0:    cond_holds = z;
         4'h1:    cond_holds = !z;
         4'h2:    cond_holds = cy;
         4'h3:    cond_holds = !cy;
         4'h4:    cond_holds = n;
         4'h5:    cond_holds = !n;
         4'h6:    cond_holds = v;
         4'h7:    cond_holds = !v;
         4'h8:    cond_holds = cy && !z;
         4'h9:    cond_holds = !(cy && !z);
         4'hA:    cond_holds = (n == v);
         4'hB:    cond_holds = (n != v);
         4'hC:    cond_holds = !z && (n == v);
         4'hD:    cond_holds = !(!z && (n == v));
         4'hE:    cond_holds = 1'b1;
         default: cond_holds = 1'b0;
      endcase
   endfunction

   assign unused_bits = ^{alu_result[32], Second_LD[2:0]};
   assign off_ext     = {{16{offset[15]}}, offset};
   assign target      = pc + off_ext;
   assign imem_req    = (state == S_FETCH);
   assign imem_addr   = pc;
   assign halted      = (state == S_HALT);

   always_comb begin
      wb_vld  = 1'b0;
      take    = 1'b0;
      do_halt = 1'b0;
      wb_idx  = dest_reg;
      wb_val  = alu_result[31:0];
      if (Special_encoding || First_LD == 2'b00) begin
         wb_vld = 1'b1;
      end else begin
         case (ALU_OC)
            3'b000: take = 1'b1;
            3'b001: take = cond_holds(B_cond, flags);
            3'b111: do_halt = 1'b1;
`ifdef EX_CTRL_BL_EN
            3'b010: begin
               take   = 1'b1;
               wb_vld = 1'b1;
               wb_idx = 3'd7;
               wb_val = pc + 32'd1;
            end
`endif
            default: ;
         endcase
      end
      pc_nxt = take ? target : pc + 32'd1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC:   state_nxt = do_halt ? S_HALT : S_WB;
         S_WB:     state_nxt = S_FETCH;
         S_HALT:   state_nxt = S_HALT;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_FETCH;
         pc        <= RESET_PC;
         pc_next_q <= RESET_PC;
         ir        <= 32'd0;
         flags     <= 4'b0000;
         wb_en     <= 1'b0;
         wb_reg    <= 3'd0;
         wb_data   <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            S_FETCH: if (imem_ack) ir <= imem_rdata;
            S_EXEC: begin
               if (!do_halt) begin
                  wb_en     <= wb_vld;
                  pc_next_q <= pc_nxt;
               end
               if (wb_vld) begin
                  wb_reg  <= wb_idx;
                  wb_data <= wb_val;
               end
               if (Special_encoding && Second_LD[3]) flags <= alu_flags;
            end
            // pc only moves on the WB->FETCH edge
            S_WB: begin
               wb_en <= 1'b0;
               pc    <= pc_next_q;
            end
            default: ;
         endcase
      end
   end

endmodule
